// File: rtl/find_global_bkt_lvl_pkg.sv
// ---------------------------------------------------------------------------
// find_global_bkt_lvl_pkg
// Shared definitions for the global backtrack resolver.
//   - Default widths and depth of the level->bin ownership table
//   - BIN_NONE: the bin id that means "before any bin was loaded"
//   - FSM state encoding
//   - clamp_lvl(): saturates a level to the last table index
// ---------------------------------------------------------------------------
package find_global_bkt_lvl_pkg;

    localparam int WIDTH_BIN_ID   = 10;
    localparam int WIDTH_LVL      = 16;
    localparam int DEPTH_LVL      = 1024;
    localparam int WIDTH_LVL_ADDR = 10;

    localparam logic [WIDTH_BIN_ID-1:0]   BIN_NONE = '0;
    localparam logic [WIDTH_LVL-1:0]      MAX_LVL  = WIDTH_LVL'(DEPTH_LVL - 1);
    localparam logic [WIDTH_LVL_ADDR-1:0] ADDR_MAX = WIDTH_LVL_ADDR'(DEPTH_LVL - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_LOOKUP,
        ST_RESP,
        ST_DONE
    } state_t;

    // Levels beyond the table saturate to the last entry before they are
    // ever narrowed to an address.
    function automatic logic [WIDTH_LVL-1:0] clamp_lvl(input logic [WIDTH_LVL-1:0] lvl);
        if (lvl > MAX_LVL) begin
            return MAX_LVL;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/find_global_bkt_lvl_lvl_bin_ram.sv
// ---------------------------------------------------------------------------
// lvl_bin_ram
// Single-port level->bin table, synchronous read, write-first.
//   clk      in   clock
//   we_i     in   write enable
//   addr_i   in   ADDR_W  read/write address
//   wdata_i  in   DATA_W  write data
//   rdata_o  out  DATA_W  data at the address sampled on the previous edge
// Contents are not reset; the resolver never reads entries it has not
// written since the last reset.
// ---------------------------------------------------------------------------
module lvl_bin_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // One access per cycle. On a write the new data is also returned on the
    // read port so the port always reflects the current table contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
            rdata_q     <= wdata_i;
        end else begin
            rdata_q     <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/find_global_bkt_lvl.sv
// ---------------------------------------------------------------------------
// find_global_bkt_lvl
// Global backtrack resolver placed directly after ctrl_bm. Keeps a table that
// records in which bin each decision level was made, and on a local UNSAT
// maps the core's backtrack level to the bin that owns it.
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   start_find_i   in   pulse: resolve bkt_lvl_core_i
//   bkt_lvl_core_i in   backtrack level from the core
//   cur_bin_i      in   bin currently loaded
//   done_find_o    out  pulse: bkt_lvl_o/bkt_bin_o valid
//   bkt_lvl_o      out  resolved backtrack level
//   bkt_bin_o      out  bin owning bkt_lvl_o
//   rec_start_i    in   pulse: record levels top+1..rec_lvl_i as rec_bin_i
//   rec_lvl_i      in   level reached at local SAT
//   rec_bin_i      in   bin that went local SAT
//   rec_done_o     out  pulse: record finished
//   top_lvl_o      out  highest recorded level (0 = empty)
//   busy_o         out  FSM not idle
//   err_ovf_o      out  sticky: a record level exceeded the table
// ---------------------------------------------------------------------------
module find_global_bkt_lvl
    import find_global_bkt_lvl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_find_i,
    input  logic [WIDTH_LVL-1:0]    bkt_lvl_core_i,
    input  logic [WIDTH_BIN_ID-1:0] cur_bin_i,
    output logic                    done_find_o,
    output logic [WIDTH_LVL-1:0]    bkt_lvl_o,
    output logic [WIDTH_BIN_ID-1:0] bkt_bin_o,
    input  logic                    rec_start_i,
    input  logic [WIDTH_LVL-1:0]    rec_lvl_i,
    input  logic [WIDTH_BIN_ID-1:0] rec_bin_i,
    output logic                    rec_done_o,
    output logic [WIDTH_LVL-1:0]    top_lvl_o,
    output logic                    busy_o,
    output logic                    err_ovf_o
);

    state_t state_q, state_d;

    logic [WIDTH_LVL-1:0]    top_q, top_d;
    logic [WIDTH_LVL-1:0]    tgt_q, tgt_d;
    logic [WIDTH_LVL-1:0]    rec_tgt_q, rec_tgt_d;
    logic [WIDTH_BIN_ID-1:0] rec_bin_q, rec_bin_d;
    logic                    find_pend_q, find_pend_d;
    logic [WIDTH_LVL-1:0]    bkt_lvl_q, bkt_lvl_d;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_q, bkt_bin_d;
    logic                    done_find_q, done_find_d;
    logic                    rec_done_q, rec_done_d;
    logic                    err_ovf_q, err_ovf_d;

    logic                      accept_rec;
    logic                      accept_find;
    logic                      fill_write;
    logic                      fill_end;
    logic                      resp_en;
    logic                      done_en;
    logic                      fill_more;
    logic [WIDTH_LVL-1:0]      top_inc;
    logic [WIDTH_LVL_ADDR-1:0] lookup_addr;
    logic                      ram_we;
    logic [WIDTH_LVL_ADDR-1:0] ram_addr;
    logic [WIDTH_BIN_ID-1:0]   ram_rdata;

    assign fill_more = (top_q < rec_tgt_q);
    assign top_inc   = top_q + WIDTH_LVL'(1);

    // Targets above the table can only ever resolve to the current bin, so
    // their read address just has to be legal; saturate before narrowing.
    assign lookup_addr = (tgt_q > MAX_LVL) ? ADDR_MAX : tgt_q[WIDTH_LVL_ADDR-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A record request beats a simultaneous find; that
    // find is parked in the pending latch and served straight after the fill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rec_start_i) begin
                    state_d = ST_FILL;
                end else if (start_find_i) begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_FILL: begin
                if (!fill_more) begin
                    state_d = find_pend_q ? ST_LOOKUP : ST_IDLE;
                end
            end
            ST_LOOKUP: state_d = ST_RESP;
            ST_RESP:   state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Per-state control strobes and table port steering. The table port is
    // shared: FILL writes the next level above top, otherwise it reads the
    // lookup target so the data is ready when RESP selects the result.
    always_comb begin
        accept_rec  = 1'b0;
        accept_find = 1'b0;
        fill_write  = 1'b0;
        fill_end    = 1'b0;
        resp_en     = 1'b0;
        done_en     = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = lookup_addr;
        case (state_q)
            ST_IDLE: begin
                accept_rec  = rec_start_i;
                accept_find = start_find_i & ~rec_start_i;
            end
            ST_FILL: begin
                fill_write = fill_more;
                fill_end   = ~fill_more;
                ram_we     = fill_more;
                if (fill_more) begin
                    ram_addr = top_inc[WIDTH_LVL_ADDR-1:0];
                end
            end
            ST_RESP: resp_en = 1'b1;
            ST_DONE: done_en = 1'b1;
            default: ;
        endcase
    end

    assign busy_o = (state_q != ST_IDLE);

    // Datapath next values. The fill target is clamped to the table once at
    // the start, and the overflow flag remembers that a clamp happened. On a
    // resolve, level 0 belongs to no bin, levels above top are still in the
    // unrecorded current bin, and everything else comes from the table.
    // Backtracking below top discards the ownership of the higher levels.
    always_comb begin
        top_d       = top_q;
        tgt_d       = tgt_q;
        rec_tgt_d   = rec_tgt_q;
        rec_bin_d   = rec_bin_q;
        find_pend_d = find_pend_q;
        bkt_lvl_d   = bkt_lvl_q;
        bkt_bin_d   = bkt_bin_q;
        done_find_d = 1'b0;
        rec_done_d  = 1'b0;
        err_ovf_d   = err_ovf_q;

        if (accept_rec) begin
            rec_tgt_d = clamp_lvl(rec_lvl_i);
            rec_bin_d = rec_bin_i;
            if (rec_lvl_i > MAX_LVL) begin
                err_ovf_d = 1'b1;
            end
            if (start_find_i) begin
                find_pend_d = 1'b1;
                tgt_d       = bkt_lvl_core_i;
            end
        end

        if (accept_find) begin
            tgt_d = bkt_lvl_core_i;
        end

        if (fill_write) begin
            top_d = top_inc;
        end

        if (fill_end) begin
            rec_done_d  = 1'b1;
            find_pend_d = 1'b0;
        end

        if (resp_en) begin
            bkt_lvl_d = tgt_q;
            if (tgt_q == '0) begin
                bkt_bin_d = BIN_NONE;
            end else if (tgt_q > top_q) begin
                bkt_bin_d = cur_bin_i;
            end else begin
                bkt_bin_d = ram_rdata;
            end
            if (tgt_q < top_q) begin
                top_d = tgt_q;
            end
        end

        if (done_en) begin
            done_find_d = 1'b1;
        end
    end

    // Datapath registers. Reset drops everything, including any fill or
    // lookup in flight, without emitting a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q       <= '0;
            tgt_q       <= '0;
            rec_tgt_q   <= '0;
            rec_bin_q   <= '0;
            find_pend_q <= 1'b0;
            bkt_lvl_q   <= '0;
            bkt_bin_q   <= '0;
            done_find_q <= 1'b0;
            rec_done_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            top_q       <= top_d;
            tgt_q       <= tgt_d;
            rec_tgt_q   <= rec_tgt_d;
            rec_bin_q   <= rec_bin_d;
            find_pend_q <= find_pend_d;
            bkt_lvl_q   <= bkt_lvl_d;
            bkt_bin_q   <= bkt_bin_d;
            done_find_q <= done_find_d;
            rec_done_q  <= rec_done_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    lvl_bin_ram #(
        .DEPTH  (DEPTH_LVL),
        .ADDR_W (WIDTH_LVL_ADDR),
        .DATA_W (WIDTH_BIN_ID)
    ) u_lvl_bin_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (rec_bin_q),
        .rdata_o (ram_rdata)
    );

    assign done_find_o = done_find_q;
    assign bkt_lvl_o   = bkt_lvl_q;
    assign bkt_bin_o   = bkt_bin_q;
    assign rec_done_o  = rec_done_q;
    assign top_lvl_o   = top_q;
    assign err_ovf_o   = err_ovf_q;

endmodule

// File: tb/tb_find_global_bkt_lvl.sv
// ---------------------------------------------------------------------------
// tb_find_global_bkt_lvl
// Self-checking bench for the global backtrack resolver. Record and find
// requests come from a vector table; expected results are queued when a
// request is driven and compared when the matching done pulse appears.
// Same-cycle requests, requests while busy, overflow and mid-fill reset are
// exercised by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_find_global_bkt_lvl;

    logic        clk;
    logic        rst_n;
    logic        start_find_i;
    logic [15:0] bkt_lvl_core_i;
    logic [9:0]  cur_bin_i;
    logic        done_find_o;
    logic [15:0] bkt_lvl_o;
    logic [9:0]  bkt_bin_o;
    logic        rec_start_i;
    logic [15:0] rec_lvl_i;
    logic [9:0]  rec_bin_i;
    logic        rec_done_o;
    logic [15:0] top_lvl_o;
    logic        busy_o;
    logic        err_ovf_o;

    typedef struct {
        bit isRec;
        int lvl;
        int bin;
        int expBin;
        int expTop;
        int expLat;
    } vec_t;

    typedef struct {
        bit isRec;
        int lvl;
        int bin;
        int top;
        int lat;
    } exp_t;

    vec_t vecs[18];
    exp_t sbQ[$];

    int compared;
    int mismatched;

    find_global_bkt_lvl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_find_i   (start_find_i),
        .bkt_lvl_core_i (bkt_lvl_core_i),
        .cur_bin_i      (cur_bin_i),
        .done_find_o    (done_find_o),
        .bkt_lvl_o      (bkt_lvl_o),
        .bkt_bin_o      (bkt_bin_o),
        .rec_start_i    (rec_start_i),
        .rec_lvl_i      (rec_lvl_i),
        .rec_bin_i      (rec_bin_i),
        .rec_done_o     (rec_done_o),
        .top_lvl_o      (top_lvl_o),
        .busy_o         (busy_o),
        .err_ovf_o      (err_ovf_o)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge, where inputs are driven
    // and outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expVal);
        compared++;
        if (act !== expVal) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expVal);
        end
    endtask

    // Pops the oldest expectation and compares it against what the DUT
    // presents at its done pulse.
    task automatic collectResult(input string tag, input bit seen, input int lat);
        exp_t e;
        e = sbQ.pop_front();
        checkOutput({tag, ".done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            checkOutput({tag, ".latency"}, 32'(lat), 32'(e.lat));
            if (!e.isRec) begin
                checkOutput({tag, ".bkt_lvl"}, 32'(bkt_lvl_o), 32'(e.lvl));
                checkOutput({tag, ".bkt_bin"}, 32'(bkt_bin_o), 32'(e.bin));
            end
            checkOutput({tag, ".top"}, 32'(top_lvl_o), 32'(e.top));
        end
    endtask

    // Drives one table vector as a single start pulse, queues its expected
    // result, then waits (bounded) for the corresponding done pulse.
    task automatic applyStimulus(input int idx);
        vec_t v;
        exp_t e;
        int   lat;
        bit   seen;
        v       = vecs[idx];
        e.isRec = v.isRec;
        e.lvl   = v.lvl;
        e.bin   = v.expBin;
        e.top   = v.expTop;
        e.lat   = v.expLat;
        sbQ.push_back(e);
        if (v.isRec) begin
            rec_lvl_i   = 16'(v.lvl);
            rec_bin_i   = 10'(v.bin);
            rec_start_i = 1'b1;
        end else begin
            bkt_lvl_core_i = 16'(v.lvl);
            cur_bin_i      = 10'(v.bin);
            start_find_i   = 1'b1;
        end
        tick();
        rec_start_i  = 1'b0;
        start_find_i = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 1100) begin
            tick();
            lat++;
            seen = v.isRec ? rec_done_o : done_find_o;
        end
        collectResult($sformatf("vec%0d", idx), seen, lat);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".done_find"}, 32'(done_find_o), 32'd0);
        checkOutput({tag, ".rec_done"}, 32'(rec_done_o), 32'd0);
        checkOutput({tag, ".busy"}, 32'(busy_o), 32'd0);
        checkOutput({tag, ".top"}, 32'(top_lvl_o), 32'd0);
        checkOutput({tag, ".err_ovf"}, 32'(err_ovf_o), 32'd0);
        checkOutput({tag, ".bkt_lvl"}, 32'(bkt_lvl_o), 32'd0);
        checkOutput({tag, ".bkt_bin"}, 32'(bkt_bin_o), 32'd0);
    endtask

    initial begin
        int recAt;
        int findAt;
        int findCnt;
        int lat;
        bit seen;

        compared   = 0;
        mismatched = 0;

        //            isRec lvl   bin expBin expTop expLat
        vecs[0]  = '{1'b0, 0,    0,  0,     0,    3};
        vecs[1]  = '{1'b1, 3,    1,  0,     3,    4};
        vecs[2]  = '{1'b1, 5,    2,  0,     5,    3};
        vecs[3]  = '{1'b0, 4,    0,  2,     4,    3};
        vecs[4]  = '{1'b0, 2,    0,  1,     2,    3};
        vecs[5]  = '{1'b1, 5,    2,  0,     5,    4};
        vecs[6]  = '{1'b0, 7,    3,  3,     5,    3};
        vecs[7]  = '{1'b0, 3,    3,  2,     3,    3};
        vecs[8]  = '{1'b1, 5,    2,  0,     5,    3};
        vecs[9]  = '{1'b0, 5,    7,  2,     5,    3};
        vecs[10] = '{1'b0, 6,    7,  7,     5,    3};
        vecs[11] = '{1'b0, 2000, 9,  9,     5,    3};
        vecs[12] = '{1'b1, 2,    6,  0,     5,    1};
        vecs[13] = '{1'b0, 1023, 3,  8,  1023,    3};
        vecs[14] = '{1'b0, 11,   3,  8,    11,    3};
        vecs[15] = '{1'b0, 10,   3,  5,    10,    3};
        vecs[16] = '{1'b0, 7,    3,  5,     7,    3};
        vecs[17] = '{1'b0, 1,    12, 12,    0,    3};

        rst_n          = 1'b0;
        start_find_i   = 1'b0;
        bkt_lvl_core_i = '0;
        cur_bin_i      = '0;
        rec_start_i    = 1'b0;
        rec_lvl_i      = '0;
        rec_bin_i      = '0;

        tick();
        tick();
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i <= 12; i++) begin
            applyStimulus(i);
            tick();
        end

        // Record and find in the same cycle: record finishes first, then the
        // parked find resolves level 6 to the bin just recorded.
        $display("[TB] same-cycle record and find");
        rec_lvl_i      = 16'd6;
        rec_bin_i      = 10'd4;
        bkt_lvl_core_i = 16'd6;
        cur_bin_i      = 10'd1;
        rec_start_i    = 1'b1;
        start_find_i   = 1'b1;
        tick();
        rec_start_i  = 1'b0;
        start_find_i = 1'b0;
        recAt  = -1;
        findAt = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (rec_done_o && recAt < 0) recAt = k;
            if (done_find_o && findAt < 0) findAt = k;
        end
        checkOutput("same.rec_done_at", 32'(recAt), 32'd2);
        checkOutput("same.done_find_at", 32'(findAt), 32'd5);
        checkOutput("same.bkt_lvl", 32'(bkt_lvl_o), 32'd6);
        checkOutput("same.bkt_bin", 32'(bkt_bin_o), 32'd4);
        checkOutput("same.top", 32'(top_lvl_o), 32'd6);

        // A find pulse during a fill is dropped.
        $display("[TB] find while busy");
        rec_lvl_i   = 16'd10;
        rec_bin_i   = 10'd5;
        rec_start_i = 1'b1;
        tick();
        rec_start_i = 1'b0;
        recAt   = -1;
        findCnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                bkt_lvl_core_i = 16'd1;
                cur_bin_i      = 10'd0;
                start_find_i   = 1'b1;
            end
            tick();
            start_find_i = 1'b0;
            if (rec_done_o && recAt < 0) recAt = k;
            if (done_find_o) findCnt++;
        end
        checkOutput("busy.rec_done_at", 32'(recAt), 32'd5);
        checkOutput("busy.find_count", 32'(findCnt), 32'd0);
        checkOutput("busy.top", 32'(top_lvl_o), 32'd10);
        checkOutput("busy.err_ovf_before", 32'(err_ovf_o), 32'd0);

        // Overflowing record: clamps to the last table entry.
        $display("[TB] overflow record");
        rec_lvl_i   = 16'd2000;
        rec_bin_i   = 10'd8;
        rec_start_i = 1'b1;
        tick();
        rec_start_i = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 1100) begin
            tick();
            lat++;
            seen = rec_done_o;
        end
        checkOutput("ovf.done_seen", 32'(seen), 32'd1);
        checkOutput("ovf.latency", 32'(lat), 32'd1014);
        checkOutput("ovf.top", 32'(top_lvl_o), 32'd1023);
        checkOutput("ovf.err_ovf", 32'(err_ovf_o), 32'd1);
        tick();

        for (int i = 13; i <= 16; i++) begin
            applyStimulus(i);
            tick();
        end

        // Reset in the middle of a fill: everything clears at once and no
        // record completion is ever reported.
        $display("[TB] reset during fill");
        rec_lvl_i   = 16'd50;
        rec_bin_i   = 10'd3;
        rec_start_i = 1'b1;
        tick();
        rec_start_i = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checkOutput("abort.busy_before", 32'(busy_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("abort");
        tick();
        tick();
        rst_n = 1'b1;
        recAt = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (rec_done_o && recAt < 0) recAt = k;
        end
        checkOutput("abort.no_rec_done", 32'(recAt), 32'hFFFF_FFFF);
        checkOutput("abort.busy_after", 32'(busy_o), 32'd0);

        applyStimulus(17);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
